vfpu_tcdm_arbiter: RTL and testbench



---
 rtl/vfpu_package.sv | 15 +
 rtl/vfpu_tcdm_arbiter_if.sv | 51 +++++
 rtl/vfpu_tcdm_arb_tag_fifo.sv | 76 +++++++
 rtl/vfpu_tcdm_arbiter.sv | 103 ++++++++++
 tb/tb_vfpu_tcdm_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vfpu_package.sv
// ---------------------------------------------------------------------------
// vfpu_package
// Types and constants shared by the VFPU TCDM arbiter slice.
//   NB_TCDM_PORTS   : number of TCDM masters exposed by the accelerator wrapper
//                     (two operand streams plus one result stream).
//   tcdm_port_idx_t : index of one of those masters; stored as a tag for every
//                     outstanding memory transaction.
// ---------------------------------------------------------------------------
package vfpu_package;

  localparam int NB_TCDM_PORTS = 3;

  typedef logic [$clog2(NB_TCDM_PORTS)-1:0] tcdm_port_idx_t;

endpackage

// File: rtl/vfpu_tcdm_arbiter_if.sv
// ---------------------------------------------------------------------------
// vfpu_tcdm_arbiter_if
// Bundle of every handshake/bus signal around the TCDM arbiter.
//   in_*  : N_PORTS upstream TCDM masters (request, payload, grant, response)
//   out_* : the single downstream TCDM slave port
// Modports:
//   slave  : the arbiter's view (consumes upstream requests, drives memory)
//   master : the environment's view (requesters plus memory model)
// ---------------------------------------------------------------------------
interface vfpu_tcdm_arbiter_if #(
  parameter int N_PORTS    = 3,
  parameter int DATA_WIDTH = 32
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  // Upstream side
  logic [N_PORTS-1:0]                 in_req;
  logic [N_PORTS-1:0]                 in_gnt;
  logic [N_PORTS-1:0][31:0]           in_add;
  logic [N_PORTS-1:0]                 in_wen;
  logic [N_PORTS-1:0][BE_WIDTH-1:0]   in_be;
  logic [N_PORTS-1:0][DATA_WIDTH-1:0] in_data;
  logic [N_PORTS-1:0][DATA_WIDTH-1:0] in_r_data;
  logic [N_PORTS-1:0]                 in_r_valid;

  // Memory side
  logic                  out_req;
  logic [31:0]           out_add;
  logic                  out_wen;
  logic [BE_WIDTH-1:0]   out_be;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_gnt;
  logic [DATA_WIDTH-1:0] out_r_data;
  logic                  out_r_valid;

  modport slave (
    input  in_req, in_add, in_wen, in_be, in_data,
    input  out_gnt, out_r_data, out_r_valid,
    output in_gnt, in_r_data, in_r_valid,
    output out_req, out_add, out_wen, out_be, out_data
  );

  modport master (
    output in_req, in_add, in_wen, in_be, in_data,
    output out_gnt, out_r_data, out_r_valid,
    input  in_gnt, in_r_data, in_r_valid,
    input  out_req, out_add, out_wen, out_be, out_data
  );

endinterface

// File: rtl/vfpu_tcdm_arb_tag_fifo.sv
// ---------------------------------------------------------------------------
// vfpu_tcdm_arb_tag_fifo
// Synchronous FIFO of port-index tags, one entry per outstanding transaction.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
//   i_push     : write i_data (ignored while full)
//   i_pop      : drop the head entry (ignored while empty)
//   i_data     : tag to store
//   o_head     : registered head entry, valid while !o_empty
//   o_full     : occupancy == DEPTH
//   o_empty    : occupancy == 0
//   o_count    : current occupancy
// ---------------------------------------------------------------------------
module vfpu_tcdm_arb_tag_fifo
  import vfpu_package::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  tcdm_port_idx_t             i_data,
  output tcdm_port_idx_t             o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  tcdm_port_idx_t r_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           w_push;
  logic           w_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (32'(ptr) == DEPTH - 1) ? '0 : ptr + 1'b1;
  endfunction

  assign o_full  = (32'(r_count) == DEPTH);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; an entry is only read after it has
  // been written, and leaving it unreset keeps it a plain register file.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/vfpu_tcdm_arbiter.sv
// ---------------------------------------------------------------------------
// vfpu_tcdm_arbiter
// Round-robin arbiter multiplexing N_PORTS TCDM masters onto one TCDM slave.
// Granted requests push their port index into a tag FIFO; in-order memory
// responses pop it to steer in_r_valid back to the originator. Request and
// response paths are purely combinational (zero added latency).
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   bus         : vfpu_tcdm_arbiter_if.slave, all in_* and out_* signals
//   outstanding : current tag FIFO occupancy
//   err         : sticky, set by a response arriving with no outstanding tag
// ---------------------------------------------------------------------------
module vfpu_tcdm_arbiter
  import vfpu_package::*;
#(
  parameter int N_PORTS    = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  vfpu_tcdm_arbiter_if.slave              bus,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] outstanding,
  output logic                            err
);

  tcdm_port_idx_t r_prio;
  logic           r_err;
  tcdm_port_idx_t w_winner;
  tcdm_port_idx_t w_cand;
  tcdm_port_idx_t w_head;
  logic           w_full;
  logic           w_empty;
  logic           w_out_req;
  logic           w_hs;
  logic           w_pop;

  // Scan from r_prio upward with wrap. Iterating downward means the last hit
  // written is the first requester at or after r_prio. With no request the
  // winner stays port 0, so the payload is never X.
  // NOTE: every always_comb output gets a default before any conditional
  // assignment, otherwise a latch is inferred.
  always_comb begin
    w_winner = '0;
    w_cand   = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      w_cand = tcdm_port_idx_t'((32'(r_prio) + 32'(i)) % N_PORTS);
      if (bus.in_req[w_cand]) w_winner = w_cand;
    end
  end

  // No bypass: a pop in this cycle does not free a slot for this cycle's push.
  assign w_out_req    = rst_n & ~w_full & (|bus.in_req);
  assign w_hs         = w_out_req & bus.out_gnt;
  assign w_pop        = rst_n & bus.out_r_valid & ~w_empty;

  assign bus.out_req  = w_out_req;
  assign bus.out_add  = bus.in_add[w_winner];
  assign bus.out_wen  = bus.in_wen[w_winner];
  assign bus.out_be   = bus.in_be[w_winner];
  assign bus.out_data = bus.in_data[w_winner];

  assign bus.in_r_data = {N_PORTS{bus.out_r_data}};

  always_comb begin
    bus.in_gnt = '0;
    if (w_hs) bus.in_gnt[w_winner] = 1'b1;
  end

  always_comb begin
    bus.in_r_valid = '0;
    if (w_pop) bus.in_r_valid[w_head] = 1'b1;
  end

  // Priority only moves on an accepted handshake, so a port stalled by the
  // memory keeps winning while it holds its request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prio <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_hs) r_prio <= (32'(w_winner) == N_PORTS - 1) ? '0 : w_winner + 1'b1;
      if (bus.out_r_valid && w_empty) r_err <= 1'b1;
    end
  end

  assign err = r_err;

  vfpu_tcdm_arb_tag_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_hs),
    .i_pop   (w_pop),
    .i_data  (w_winner),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (outstanding)
  );

endmodule

// File: tb/tb_vfpu_tcdm_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vfpu_tcdm_arbiter
// Self-checking bench for vfpu_tcdm_arbiter (FIFO_DEPTH=2 so the full
// condition is reached often). A queue-based reference model tracks the
// outstanding tags, the round-robin priority and the error flag; every cycle
// the DUT's combinational outputs are compared against it, followed by
// directed scenarios and a randomized run.
// ---------------------------------------------------------------------------
module tb_vfpu_tcdm_arbiter;

  localparam int N     = 3;
  localparam int DEPTH = 2;
  localparam int DW    = 32;
  localparam int OW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vfpu_tcdm_arbiter_if #(.N_PORTS(N), .DATA_WIDTH(DW)) bus ();

  logic [OW-1:0] outstanding;
  logic          err;

  vfpu_tcdm_arbiter #(
    .N_PORTS    (N),
    .FIFO_DEPTH (DEPTH),
    .DATA_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .outstanding (outstanding),
    .err         (err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int tags[$];
  int prio  = 0;
  bit m_err = 1'b0;

  // Last sampled DUT outputs, for directed constant checks
  logic [N-1:0] last_gnt;
  logic [N-1:0] last_rv;
  logic         last_oreq;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called right after a falling edge with inputs already driven: checks the
  // combinational outputs, advances the model across the next rising edge and
  // returns at the following falling edge.
  task automatic tick();
    int           win;
    bit           full;
    bit           e_req;
    logic [N-1:0] e_gnt;
    logic [N-1:0] e_rv;
    #1;
    full = (tags.size() == DEPTH);
    win  = -1;
    for (int i = 0; i < N; i++) begin
      int p;
      p = (prio + i) % N;
      if (win < 0 && bus.in_req[p]) win = p;
    end
    e_req = rst_n && !full && (win >= 0);
    e_gnt = '0;
    if (e_req && bus.out_gnt) e_gnt[win] = 1'b1;
    e_rv = '0;
    if (rst_n && bus.out_r_valid && tags.size() > 0) e_rv[tags[0]] = 1'b1;

    check("out_req", bus.out_req, e_req);
    if (e_req) begin
      check("out_add",  bus.out_add,  bus.in_add[win]);
      check("out_wen",  bus.out_wen,  bus.in_wen[win]);
      check("out_be",   bus.out_be,   bus.in_be[win]);
      check("out_data", bus.out_data, bus.in_data[win]);
    end
    check("in_gnt", bus.in_gnt, e_gnt);
    check("in_r_valid", bus.in_r_valid, e_rv);
    if (bus.out_r_valid) begin
      for (int q = 0; q < N; q++) check("in_r_data", bus.in_r_data[q], bus.out_r_data);
    end
    check("outstanding", outstanding, tags.size());
    check("err", err, m_err);

    last_gnt  = bus.in_gnt;
    last_rv   = bus.in_r_valid;
    last_oreq = bus.out_req;

    if (!rst_n) begin
      tags.delete();
      prio  = 0;
      m_err = 1'b0;
    end else begin
      if (bus.out_r_valid) begin
        if (tags.size() > 0) void'(tags.pop_front());
        else m_err = 1'b1;
      end
      if (e_gnt != '0) begin
        tags.push_back(win);
        prio = (win + 1) % N;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    bus.in_req      = '0;
    bus.in_wen      = '0;
    bus.in_be       = '0;
    bus.out_gnt     = 1'b0;
    bus.out_r_valid = 1'b0;
    bus.out_r_data  = '0;
    for (int p = 0; p < N; p++) begin
      bus.in_add[p]  = 32'h1000 + 32'(p) * 32'h10;
      bus.in_data[p] = 32'hC0DE_0000 + 32'(p);
    end
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int k = 0; k < 16 && tags.size() > 0; k++) begin
      idle();
      bus.out_r_valid = 1'b1;
      bus.out_r_data  = $urandom;
      tick();
    end
    check("drain_empty", outstanding, 0);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    do_reset();

    // Single read from port 0
    idle();
    bus.in_req[0] = 1'b1; bus.in_add[0] = 32'h100; bus.in_wen[0] = 1'b1;
    bus.in_be[0] = 4'hF; bus.out_gnt = 1'b1;
    tick();
    check("single_gnt", last_gnt, 3'b001);
    check("single_occ1", outstanding, 1);
    idle();
    bus.out_r_valid = 1'b1; bus.out_r_data = 32'hDEAD_BEEF;
    tick();
    check("single_rv", last_rv, 3'b001);
    check("single_rdata", bus.in_r_data[0], 32'hDEAD_BEEF);
    check("single_occ0", outstanding, 0);

    // Fairness: all ports request, response one cycle after each grant
    do_reset();
    for (int k = 0; k < 7; k++) begin
      idle();
      bus.in_req      = '1;
      bus.out_gnt     = (k < 6);
      bus.out_r_valid = (k > 0);
      bus.out_r_data  = 32'hA000_0000 + 32'(k);
      tick();
      if (k < 6) check("fair_gnt", last_gnt, 3'b001 << (k % 3));
      if (k > 0) check("fair_rv", last_rv, 3'b001 << ((k - 1) % 3));
    end

    // Memory stall: ports 1 and 2 wait while out_gnt=0
    do_reset();
    for (int k = 0; k < 3; k++) begin
      idle();
      bus.in_req = 3'b110;
      tick();
      check("stall_gnt", last_gnt, 3'b000);
      check("stall_oreq", last_oreq, 1'b1);
    end
    idle(); bus.in_req = 3'b110; bus.out_gnt = 1'b1;
    tick();
    check("stall_first", last_gnt, 3'b010);
    idle(); bus.in_req = 3'b100; bus.out_gnt = 1'b1;
    tick();
    check("stall_second", last_gnt, 3'b100);
    drain();

    // Full FIFO with responses withheld, then no-bypass release
    for (int k = 0; k < 2; k++) begin
      idle(); bus.in_req = 3'b001; bus.out_gnt = 1'b1;
      tick();
      check("full_fill", last_gnt, 3'b001);
    end
    idle(); bus.in_req = 3'b001; bus.out_gnt = 1'b1;
    tick();
    check("full_oreq", last_oreq, 1'b0);
    check("full_gnt", last_gnt, 3'b000);
    idle(); bus.in_req = 3'b001; bus.out_gnt = 1'b1; bus.out_r_valid = 1'b1;
    tick();
    check("full_nobypass", last_oreq, 1'b0);
    idle(); bus.in_req = 3'b001; bus.out_gnt = 1'b1;
    tick();
    check("full_resume_req", last_oreq, 1'b1);
    check("full_resume_gnt", last_gnt, 3'b001);
    drain();

    // Spurious response sets sticky err
    idle(); bus.out_r_valid = 1'b1; bus.out_r_data = 32'h1234;
    tick();
    check("spur_rv", last_rv, 3'b000);
    for (int k = 0; k < 3; k++) begin
      idle();
      tick();
      check("err_sticky", err, 1'b1);
    end

    // Reset with two transactions in flight
    for (int k = 0; k < 2; k++) begin
      idle(); bus.in_req = 3'b001; bus.out_gnt = 1'b1;
      tick();
    end
    check("mid_occ", outstanding, 2);
    do_reset();
    check("rst_occ", outstanding, 0);
    check("rst_err", err, 1'b0);
    idle(); bus.out_r_valid = 1'b1;
    tick();
    check("late_rv", last_rv, 3'b000);
    check("late_err", err, 1'b1);
    idle(); bus.in_req = 3'b111; bus.out_gnt = 1'b1;
    tick();
    check("rst_prio", last_gnt, 3'b001);
    drain();

    // Randomized traffic; requesters hold payload until granted and the
    // memory only answers outstanding requests
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < N; p++) begin
        if (!bus.in_req[p] || last_gnt[p]) begin
          bus.in_req[p]  = ($urandom_range(0, 2) != 0);
          bus.in_add[p]  = $urandom;
          bus.in_wen[p]  = 1'($urandom_range(0, 1));
          bus.in_be[p]   = 4'($urandom);
          bus.in_data[p] = $urandom;
        end
      end
      bus.out_gnt     = ($urandom_range(0, 3) != 0);
      bus.out_r_valid = (tags.size() > 0) && ($urandom_range(0, 1) == 1);
      bus.out_r_data  = $urandom;
      tick();
    end
    drain();
    check("final_err", err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
